key_debounce_encoder: RTL



---
 rtl/key_pkg.sv | 75 +++++++
 rtl/key_event_fifo.sv | 60 ++++++
 rtl/key_debounce_encoder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Keypad package: key width, key count, key code constants and the
// code <-> one-hot helpers used by the key front-end and calculator1.
// Key map: sw[11] is key 0 down to sw[2] key 9, sw[1] is OP, sw[0] is EQ.
package key_pkg;

   localparam int KEY_W    = 4;
   localparam int NUM_KEYS = 12;

   localparam logic [KEY_W-1:0] KEY_0  = 4'h0;
   localparam logic [KEY_W-1:0] KEY_1  = 4'h1;
   localparam logic [KEY_W-1:0] KEY_2  = 4'h2;
   localparam logic [KEY_W-1:0] KEY_3  = 4'h3;
   localparam logic [KEY_W-1:0] KEY_4  = 4'h4;
   localparam logic [KEY_W-1:0] KEY_5  = 4'h5;
   localparam logic [KEY_W-1:0] KEY_6  = 4'h6;
   localparam logic [KEY_W-1:0] KEY_7  = 4'h7;
   localparam logic [KEY_W-1:0] KEY_8  = 4'h8;
   localparam logic [KEY_W-1:0] KEY_9  = 4'h9;
   localparam logic [KEY_W-1:0] KEY_OP = 4'hA;
   localparam logic [KEY_W-1:0] KEY_EQ = 4'hB;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HELD    = 2'd1,
      ST_INVALID = 2'd2
   } key_state_t;

   // Key code to switch-vector position; unused codes map to no key.
   function automatic logic [NUM_KEYS-1:0] key_to_onehot(input logic [KEY_W-1:0] code);
      logic [NUM_KEYS-1:0] v;
      case (code)
         KEY_0:   v = 12'h800;
         KEY_1:   v = 12'h400;
         KEY_2:   v = 12'h200;
         KEY_3:   v = 12'h100;
         KEY_4:   v = 12'h080;
         KEY_5:   v = 12'h040;
         KEY_6:   v = 12'h020;
         KEY_7:   v = 12'h010;
         KEY_8:   v = 12'h008;
         KEY_9:   v = 12'h004;
         KEY_OP:  v = 12'h002;
         KEY_EQ:  v = 12'h001;
         default: v = 12'h000;
      endcase
      return v;
   endfunction

   // Switch vector to key code; only meaningful for a one-hot vector.
   function automatic logic [KEY_W-1:0] onehot_to_key(input logic [NUM_KEYS-1:0] v);
      logic [KEY_W-1:0] code;
      case (v)
         12'h800: code = KEY_0;
         12'h400: code = KEY_1;
         12'h200: code = KEY_2;
         12'h100: code = KEY_3;
         12'h080: code = KEY_4;
         12'h040: code = KEY_5;
         12'h020: code = KEY_6;
         12'h010: code = KEY_7;
         12'h008: code = KEY_8;
         12'h004: code = KEY_9;
         12'h002: code = KEY_OP;
         12'h001: code = KEY_EQ;
         default: code = KEY_0;
      endcase
      return code;
   endfunction

   // True when exactly one switch is closed.
   function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
      return (v != 12'h000) && ((v & (v - 12'h001)) == 12'h000);
   endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous key event FIFO, power-of-two depth, no fall-through.
// A push while full is dropped unless a pop happens in the same cycle.
module key_event_fifo
   import key_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = KEY_W
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_empty,
   output logic         o_full
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == FULL_CNT);
   assign o_data  = r_mem[r_rd_ptr];
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);

   // Storage, wrapping pointers and occupancy count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/key_debounce_encoder.sv
// Keypad front-end: 2-flop synchroniser, debounce, press-detect FSM,
// key encoder and event FIFO with valid/ready delivery.
// Optional auto-repeat while a key is held: define KEY_REPEAT_EN.
module key_debounce_encoder
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int FIFO_DEPTH      = 4
`ifdef KEY_REPEAT_EN
   ,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
`endif
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] sw,
   input  logic                key_ready,
   output logic                key_valid,
   output logic [KEY_W-1:0]    key_code,
   output logic [NUM_KEYS-1:0] key_onehot,
   output logic                key_multi,
   output logic                key_ovf
);

   localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_KEYS-1:0] r_sync1;
   logic [NUM_KEYS-1:0] r_sync2;
   logic [NUM_KEYS-1:0] r_prev;
   logic [NUM_KEYS-1:0] r_stable;
   logic [CNT_W-1:0]    r_db_cnt;
   key_state_t          r_state;
   key_state_t          w_state_next;
   logic [NUM_KEYS-1:0] r_held_vec;
   logic                w_push;
   logic [KEY_W-1:0]    w_push_code;
   logic                w_multi;
   logic                r_multi;
   logic                r_ovf;
   logic                w_pop;
   logic                w_fifo_empty;
   logic                w_fifo_full;
   logic [KEY_W-1:0]    w_fifo_code;
   logic                w_rep_fire;

   // Two-flop synchroniser on the raw asynchronous switches.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= sw;
         r_sync2 <= r_sync1;
      end
   end

   // Debounce: accept a new vector after DEBOUNCE_CYCLES equal consecutive samples.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prev   <= '0;
         r_db_cnt <= '0;
         r_stable <= '0;
      end else begin
         r_prev <= r_sync2;
         if (r_sync2 != r_prev) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt != CNT_MAX) begin
            r_db_cnt <= r_db_cnt + CNT_W'(1);
         end else if (r_sync2 != r_stable) begin
            r_stable <= r_sync2;
         end else begin
            r_stable <= r_stable;
         end
      end
   end

`ifdef KEY_REPEAT_EN
   localparam int REP_W = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

   logic [REP_W-1:0] r_rep_cnt;
   logic             r_rep_first;

   // Repeat fires after REPEAT_DELAY held cycles, then every REPEAT_PERIOD.
   always_comb begin
      w_rep_fire = 1'b0;
      if (r_rep_first) begin
         w_rep_fire = (r_rep_cnt == REP_W'(REPEAT_DELAY - 1));
      end else begin
         w_rep_fire = (r_rep_cnt == REP_W'(REPEAT_PERIOD - 1));
      end
   end

   // Hold counter runs only while in HELD and restarts after each repeat.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rep_cnt   <= '0;
         r_rep_first <= 1'b1;
      end else if (r_state != ST_HELD) begin
         r_rep_cnt   <= '0;
         r_rep_first <= 1'b1;
      end else if (w_rep_fire) begin
         r_rep_cnt   <= '0;
         r_rep_first <= 1'b0;
      end else begin
         r_rep_cnt   <= r_rep_cnt + REP_W'(1);
      end
   end
`else
   assign w_rep_fire = 1'b0;
`endif

   // Press-detect FSM on the debounced vector: one push per accepted press.
   always_comb begin
      w_state_next = r_state;
      w_push       = 1'b0;
      w_multi      = 1'b0;
      w_push_code  = onehot_to_key(r_stable);
      case (r_state)
         ST_IDLE: begin
            if (r_stable == 12'h000) begin
               w_state_next = ST_IDLE;
            end else if (is_onehot(r_stable)) begin
               w_push       = 1'b1;
               w_state_next = ST_HELD;
            end else begin
               w_multi      = 1'b1;
               w_state_next = ST_INVALID;
            end
         end
         ST_HELD: begin
            if (r_stable == 12'h000) begin
               w_state_next = ST_IDLE;
            end else if (r_stable != r_held_vec) begin
               w_multi      = 1'b1;
               w_state_next = ST_INVALID;
            end else begin
               w_push       = w_rep_fire;
               w_state_next = ST_HELD;
            end
         end
         ST_INVALID: begin
            if (r_stable == 12'h000) begin
               w_state_next = ST_IDLE;
            end else begin
               w_state_next = ST_INVALID;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // FSM state, held key, and the registered multi/overflow pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_held_vec <= '0;
         r_multi    <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if ((r_state == ST_IDLE) && (w_state_next == ST_HELD)) begin
            r_held_vec <= r_stable;
         end
         r_multi <= w_multi;
         r_ovf   <= w_push & w_fifo_full & ~w_pop;
      end
   end

   assign w_pop = ~w_fifo_empty & key_ready;

   key_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (KEY_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_push_code),
      .i_pop   (w_pop),
      .o_data  (w_fifo_code),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full)
   );

   // One-hot copy of the head key, present only in the cycle it is taken.
   always_comb begin
      key_onehot = '0;
      if (w_pop) begin
         key_onehot = key_to_onehot(w_fifo_code);
      end else begin
         key_onehot = '0;
      end
   end

   assign key_valid = ~w_fifo_empty;
   assign key_code  = w_fifo_code;
   assign key_multi = r_multi;
   assign key_ovf   = r_ovf;

endmodule
